mod15361_rr_sched: RTL
======================

Name: mod15361_rr_sched

Overview:
Round-robin scheduler that shares one modmul15361s reduction pipeline among NREQ requesters. modmul15361s takes a signed 27-bit inZ and returns a signed 14-bit outZ, 3 clocks later, congruent to inZ mod 15361. This block:
- arbitrates one issue per clock;
- tags each issue with its requester ID and carries the tag through a LAT-deep shadow pipeline;
- steers each result back to its owner as a one-hot valid pulse.

It sits between the NTT/polynomial-multiply lanes and the single shared reducer.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, equal to clog2(NREQ)
LAT, 3, reducer latency in clocks; must equal the modmul15361s pipeline depth
DW_IN, 27, signed input width
DW_OUT, 14, signed output width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both high
req_data  in  NREQ*DW_IN  packed signed operands; requester i occupies bits [i*DW_IN +: DW_IN]
resp_valid  out  NREQ  one-hot result strobe
resp_id  out  IDW  ID of the requester owning resp_data
resp_data  out  DW_OUT  signed reduced value
busy  out  1  high while any slot in the tag pipeline is valid
inflight  out  clog2(LAT+1)  number of valid slots in the tag pipeline

Behaviour:
- Reset: resp_valid=0, resp_id=0, busy=0, inflight=0, req_ready=0 during the reset cycle, round-robin pointer=0, all tag valid bits cleared. The reducer's rst is tied to rst.
- Arbitration (combinational from registered state):
  - Scan starts at pointer ptr and wraps modulo NREQ.
  - The first i with req_valid[i] gets req_ready[i]=1; at most one ready is high.
  - No requester valid: all ready=0, inZ driven to 0.
- req_ready does not depend on downstream state. Results have no backpressure; consumers must accept resp_valid unconditionally.
- On a grant to i:
  - inZ = req_data[i];
  - ptr <= (i+1) mod NREQ on the next edge;
  - tag slot 0 <= {1, i}.
- No grant: ptr unchanged; slot 0 <= {0, 0}.
- Tag pipeline: slot k+1 <= slot k for k = 0..LAT-2, so a tag reaches the last slot exactly LAT clocks after its issue edge.
- Output:
  - resp_valid = onehot(last.id) & {NREQ{last.valid}}, resp_id = last.id, resp_data = outZ.
  - All three are registered-aligned with outZ; no extra stage, total latency = LAT clocks from the accepted edge.
- Data contract: resp_data is congruent to the operand mod 15361 and lies in [-8192, 8191]. The reducer's raw output is passed through unmodified and is not forced to the centred range [-7680, 7680].
- Throughput: 1 result per clock sustained. A single requester held valid is granted every cycle (ptr returns to it when it is the only one valid).
- inflight = popcount of the tag valid bits; busy = (inflight != 0).
- Reset mid-operation: all tags are dropped, and no resp_valid is asserted for operations issued before reset. The first grant can occur on the cycle after rst deasserts.
- Simultaneous request and response for the same requester in one cycle is legal and independent.
- req_data is sampled only in the grant cycle; a requester may change its data after being granted.

Decomposition:
- Package mod15361_pkg holds:
  - Q = 15361, QHALF = 7680;
  - DW_IN = 27, DW_OUT = 14, LAT = 3;
  - typedef tag_t {valid, id[IDW-1:0]}.
- The round-robin arbiter is a natural sub-module, rr_arb (req, ptr -> grant one-hot, grant_id, any). Its pointer register lives in mod15361_rr_sched.
- modmul15361s is instantiated unmodified.

Test Plan:
- Single requester 0 sends 27'sd15361, then 27'sd7681, then -27'sd1 on consecutive cycles -> resp_valid[0] at cycles +3, +4, +5; resp_data is congruent to 0, -7680 and -1 mod 15361, and each lies in [-8192, 8191].
- All 4 requesters valid continuously for 8 cycles, ptr=0 at start -> grants 0,1,2,3,0,1,2,3; resp_id follows the same sequence 3 cycles later; inflight settles at 3.
- Requesters 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3; requester 1 is never starved more than NREQ-1 cycles.
- Random 27-bit operands on all requesters, 2^16 transactions -> every response is congruent to its operand mod 15361; each response count per requester matches its accepted count.
- rst asserted for 1 cycle while inflight=3 -> no resp_valid in the following 3 cycles, busy=0 immediately after the reset edge, ptr=0.
- Idle for 10 cycles after traffic -> resp_valid=0, busy=0, inZ=0.

Source files
------------

// File: rtl/mod15361_pkg.sv
// Shared constants and the tag record carried alongside each reduction.
package mod15361_pkg;

    localparam int Q      = 15361;
    localparam int QHALF  = 7680;
    localparam int DW_IN  = 27;
    localparam int DW_OUT = 14;
    localparam int LAT    = 3;
    localparam int NREQ   = 4;
    localparam int IDW    = $clog2(NREQ);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/mod15361_rr_sched_rr_arb.sv
// Round-robin priority pick: first asserted request at or after ptr, wrapping.
module rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/modmul15361s.sv
// Three-stage signed reducer: outZ == inZ (mod 15361), outZ in [-8192, 8191].
module modmul15361s (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [26:0] inZ,
    output logic signed [13:0] outZ
);

    // 2^14 == 2^10 - 1 (mod 15361), so hi*2^14 + lo folds to hi*1023 + lo
    logic [23:0]        f1, s1;
    logic [19:0]        f2, s2;
    logic [16:0]        f3;
    logic signed [16:0] w;
    logic signed [13:0] corr;

    always_comb begin
        f1 = ({{11{inZ[26]}}, inZ[26:14]} << 10) - {{11{inZ[26]}}, inZ[26:14]}
             + {10'd0, inZ[13:0]};
        f2 = ({{10{s1[23]}}, s1[23:14]} << 10) - {{10{s1[23]}}, s1[23:14]}
             + {6'd0, s1[13:0]};
        f3 = ({{11{s2[19]}}, s2[19:14]} << 10) - {{11{s2[19]}}, s2[19:14]}
             + {3'd0, s2[13:0]};
        w  = f3;
        if (w > 17'sd23552)
            corr = 14'(w - 17'sd30722);
        else if (w > 17'sd8191)
            corr = 14'(w - 17'sd15361);
        else if (w < -17'sd8192)
            corr = 14'(w + 17'sd15361);
        else
            corr = 14'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            outZ <= '0;
        end else begin
            s1   <= f1;
            s2   <= f2;
            outZ <= corr;
        end
    end

endmodule

// File: rtl/mod15361_rr_sched.sv
// Shares one modmul15361s among NREQ requesters; tags ride a LAT-deep shadow pipe.
module mod15361_rr_sched
    import mod15361_pkg::*;
#(
    parameter int unsigned NREQ   = mod15361_pkg::NREQ,
    parameter int unsigned IDW    = mod15361_pkg::IDW,
    parameter int unsigned LAT    = mod15361_pkg::LAT,
    parameter int unsigned DW_IN  = mod15361_pkg::DW_IN,
    parameter int unsigned DW_OUT = mod15361_pkg::DW_OUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DW_IN-1:0]    req_data,
    output logic [NREQ-1:0]          resp_valid,
    output logic [IDW-1:0]           resp_id,
    output logic [DW_OUT-1:0]        resp_data,
    output logic                     busy,
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int unsigned CW = $clog2(LAT + 1);

    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             any;
    logic [DW_IN-1:0] in_z;
    logic [13:0]      out_z;
    tag_t             tags [LAT];
    logic [CW-1:0]    cnt;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    modmul15361s u_red (
        .clk  (clk),
        .rst  (rst),
        .inZ  (in_z),
        .outZ (out_z)
    );

    always_comb begin
        req_ready = rst ? '0 : grant;
        in_z      = any ? req_data[32'(grant_id)*DW_IN +: DW_IN] : '0;
        ptr_nxt   = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int unsigned k = 0; k < LAT; k++)
                tags[k] <= '0;
        end else begin
            if (any)
                ptr <= ptr_nxt;
            tags[0] <= any ? tag_t'{valid: 1'b1, id: grant_id} : '0;
            for (int unsigned k = 1; k < LAT; k++)
                tags[k] <= tags[k-1];
        end
    end

    always_comb begin
        resp_valid = '0;
        if (tags[LAT-1].valid)
            resp_valid[tags[LAT-1].id] = 1'b1;
        resp_id   = tags[LAT-1].id;
        resp_data = DW_OUT'(out_z);
        cnt       = '0;
        for (int unsigned k = 0; k < LAT; k++)
            cnt = cnt + CW'(tags[k].valid);
        inflight  = cnt;
        busy      = (cnt != '0);
    end

endmodule
